// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg: shared Y86-64 register IDs and register-file default widths.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ID_W_DEF   = 4;

  typedef enum logic [3:0] {
    RAX   = 4'h0,
    RCX   = 4'h1,
    RDX   = 4'h2,
    RBX   = 4'h3,
    RSP   = 4'h4,
    RBP   = 4'h5,
    RSI   = 4'h6,
    RDI   = 4'h7,
    R8    = 4'h8,
    R9    = 4'h9,
    R10   = 4'hA,
    R11   = 4'hB,
    R12   = 4'hC,
    R13   = 4'hD,
    R14   = 4'hE,
    RNONE = 4'hF
  } reg_id_e;

  localparam int RSP_ID_DEF = int'(RSP);
  localparam int RNONE_ID   = int'(RNONE);

endpackage

`default_nettype wire

// File: rtl/regfile_bypass.sv
// ----------------------------------------------------------------------------
// regfile_bypass: one read port, stored value or same-cycle write data (M over E).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_bypass #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int NREGS  = 15,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ID_W-1:0]   i_src,
  input  logic [DATA_W-1:0] i_stored,
  input  logic [ID_W-1:0]   i_dst_e,
  input  logic [DATA_W-1:0] i_val_e,
  input  logic              i_we_e,
  input  logic [ID_W-1:0]   i_dst_m,
  input  logic [DATA_W-1:0] i_val_m,
  input  logic              i_we_m,
  output logic [DATA_W-1:0] o_val
);

  localparam logic [ID_W-1:0] c_RNONE = '1;

  logic w_src_valid;

  assign w_src_valid = (i_src != c_RNONE) && (int'(i_src) < NREGS);

  always_comb begin
    o_val = '0;
    if (w_src_valid) begin
      o_val = i_stored;
      // M is checked first so the forwarded value matches what the edge commits
      if (BYPASS) begin
        if (i_we_m && (i_dst_m == i_src)) begin
          o_val = i_val_m;
        end else if (i_we_e && (i_dst_e == i_src)) begin
          o_val = i_val_e;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_2r2w.sv
// ----------------------------------------------------------------------------
// regfile_2r2w: Y86-64 register file, two combinational reads, two writes (E, M).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                NREGS    = 15,
  parameter int                ID_W     = ID_W_DEF,
  parameter int                RSP_ID   = RSP_ID_DEF,
  parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(10),
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   srcA,
  input  logic [ID_W-1:0]   srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ID_W-1:0]   dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic              weE,
  input  logic [ID_W-1:0]   dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              weM,
  input  logic [ID_W-1:0]   dbg_id,
  output logic [DATA_W-1:0] dbg_val,
  output logic              wr_err
);

  localparam logic [ID_W-1:0] c_RNONE  = '1;
  localparam int              c_VIEW_N = 2 ** ID_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_wr_err;
  logic [DATA_W-1:0] w_view [c_VIEW_N];
  logic              w_wr_e;
  logic              w_wr_m;
  logic              w_err_e;
  logic              w_err_m;

  function automatic logic id_valid(input logic [ID_W-1:0] id);
    return (id != c_RNONE) && (int'(id) < NREGS);
  endfunction

  assign w_wr_e  = weE && id_valid(dstE);
  assign w_wr_m  = weM && id_valid(dstM);
  assign w_err_e = weE && (dstE != c_RNONE) && !id_valid(dstE);
  assign w_err_m = weM && (dstM != c_RNONE) && !id_valid(dstM);

  // M is assigned after E so it wins a same-register collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == RSP_ID) ? RSP_INIT : DATA_W'(i);
      end
      r_wr_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_e && (dstE == ID_W'(i))) r_regs[i] <= valE;
        if (w_wr_m && (dstM == ID_W'(i))) r_regs[i] <= valM;
      end
      r_wr_err <= w_err_e || w_err_m;
    end
  end

  // Full ID-space view: unimplemented IDs and RNONE read as zero
  generate
    for (genvar k = 0; k < c_VIEW_N; k++) begin : g_view
      if ((k < NREGS) && (k != c_VIEW_N - 1)) begin : g_live
        assign w_view[k] = r_regs[k];
      end else begin : g_pad
        assign w_view[k] = '0;
      end
    end
  endgenerate

  assign dbg_val = w_view[dbg_id];
  assign wr_err  = r_wr_err;

  regfile_bypass #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_port_a (
    .i_src    (srcA),
    .i_stored (w_view[srcA]),
    .i_dst_e  (dstE),
    .i_val_e  (valE),
    .i_we_e   (weE),
    .i_dst_m  (dstM),
    .i_val_m  (valM),
    .i_we_m   (weM),
    .o_val    (valA)
  );

  regfile_bypass #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_port_b (
    .i_src    (srcB),
    .i_stored (w_view[srcB]),
    .i_dst_e  (dstE),
    .i_val_e  (valE),
    .i_we_e   (weE),
    .i_dst_m  (dstM),
    .i_val_m  (valM),
    .i_we_m   (weM),
    .o_val    (valB)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r2w.sv
// ----------------------------------------------------------------------------
// tb_regfile_2r2w: three configurations of regfile_2r2w against an array model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_2r2w;

  localparam int NK = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  srcA = '0, srcB = '0, dstE = '0, dstM = '0, dbg_id = '0;
  logic [63:0] valE = '0, valM = '0;
  logic        weE = 1'b0, weM = 1'b0;

  logic [63:0] a0, b0, d0, a1, b1, d1;
  logic [31:0] a2, b2, d2;
  logic        e0, e1, e2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_2r2w dut0 (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(a0), .valB(b0),
    .dstE(dstE), .valE(valE), .weE(weE), .dstM(dstM), .valM(valM), .weM(weM),
    .dbg_id(dbg_id), .dbg_val(d0), .wr_err(e0)
  );

  regfile_2r2w #(.NREGS(14), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(a1), .valB(b1),
    .dstE(dstE), .valE(valE), .weE(weE), .dstM(dstM), .valM(valM), .weM(weM),
    .dbg_id(dbg_id), .dbg_val(d1), .wr_err(e1)
  );

  regfile_2r2w #(.DATA_W(32), .NREGS(8), .RSP_INIT(32'h100)) dut2 (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(a2), .valB(b2),
    .dstE(dstE), .valE(valE[31:0]), .weE(weE), .dstM(dstM), .valM(valM[31:0]), .weM(weM),
    .dbg_id(dbg_id), .dbg_val(d2), .wr_err(e2)
  );

  logic [63:0] obs_a [NK];
  logic [63:0] obs_b [NK];
  logic [63:0] obs_d [NK];
  logic        obs_e [NK];

  always_comb begin
    obs_a[0] = a0;  obs_b[0] = b0;  obs_d[0] = d0;  obs_e[0] = e0;
    obs_a[1] = a1;  obs_b[1] = b1;  obs_d[1] = d1;  obs_e[1] = e1;
    obs_a[2] = {32'b0, a2};  obs_b[2] = {32'b0, b2};  obs_d[2] = {32'b0, d2};  obs_e[2] = e2;
  end

  // Reference model: committed contents of each configuration
  logic [63:0] mdl [NK][16];
  logic        exp_err [NK];

  function automatic int nregs_of(int k);
    return (k == 0) ? 15 : (k == 1) ? 14 : 8;
  endfunction

  function automatic logic [63:0] rsp_of(int k);
    return (k == 2) ? 64'h100 : 64'd10;
  endfunction

  function automatic logic [63:0] mask_of(int k);
    return (k == 2) ? 64'hFFFF_FFFF : '1;
  endfunction

  function automatic bit bypass_of(int k);
    return k != 1;
  endfunction

  function automatic bit valid_of(int k, logic [3:0] id);
    return (id != 4'hF) && (int'(id) < nregs_of(k));
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 16; i++) begin
        mdl[k][i] = (i >= nregs_of(k)) ? 64'd0 : (i == 4) ? rsp_of(k) : 64'(i);
      end
      exp_err[k] = 1'b0;
    end
  endfunction

  function automatic logic [63:0] exp_read(int k, logic [3:0] id, bit use_bypass);
    if (!valid_of(k, id)) return 64'd0;
    if (use_bypass && bypass_of(k)) begin
      if (weM && dstM == id) return valM & mask_of(k);
      if (weE && dstE == id) return valE & mask_of(k);
    end
    return mdl[k][id];
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < NK; k++) begin
      exp_err[k] = (weE && dstE != 4'hF && !valid_of(k, dstE)) ||
                   (weM && dstM != 4'hF && !valid_of(k, dstM));
      if (weE && valid_of(k, dstE)) mdl[k][dstE] = valE & mask_of(k);
      if (weM && valid_of(k, dstM)) mdl[k][dstM] = valM & mask_of(k);
    end
  endfunction

  task automatic test_reset();
    weE = 1'b1; dstE = 4'h0; valE = 64'hDEAD;
    weM = 1'b1; dstM = 4'h5; valM = 64'hBEEF;
    dbg_id = 4'h4;
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (d0 !== 64'd10) begin
      n_fail++; $display("FAIL reset_async_rsp got %h expected %h", d0, 64'd10);
    end
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < nregs_of(k); i++) begin
        dbg_id = 4'(i); #1;
        n_tests++;
        if (obs_d[k] !== mdl[k][i]) begin
          n_fail++; $display("FAIL reset_image k=%0d id=%0d got %h expected %h", k, i, obs_d[k], mdl[k][i]);
        end
      end
      n_tests++;
      if (obs_e[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_wr_err k=%0d got %b expected 0", k, obs_e[k]);
      end
    end
    weE = 1'b0; weM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dual_write();
    @(posedge clk); #1;
    weE = 1'b1; dstE = 4'h2; valE = 64'hAA;
    weM = 1'b1; dstM = 4'h3; valM = 64'hBB;
    @(posedge clk);
    model_edge();
    #1;
    weE = 1'b0; weM = 1'b0;
    dbg_id = 4'h2; #1;
    n_tests++;
    if (d0 !== 64'hAA) begin
      n_fail++; $display("FAIL dual_write_e got %h expected %h", d0, 64'hAA);
    end
    dbg_id = 4'h3; #1;
    n_tests++;
    if (d0 !== 64'hBB) begin
      n_fail++; $display("FAIL dual_write_m got %h expected %h", d0, 64'hBB);
    end
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 16; i++) begin
        dbg_id = 4'(i); #1;
        n_tests++;
        if (obs_d[k] !== mdl[k][i]) begin
          n_fail++; $display("FAIL dual_write_image k=%0d id=%0d got %h expected %h", k, i, obs_d[k], mdl[k][i]);
        end
      end
    end
  endtask

  task automatic test_collision();
    @(posedge clk); #1;
    weE = 1'b1; dstE = 4'h4; valE = 64'h20;
    weM = 1'b1; dstM = 4'h4; valM = 64'h30;
    srcA = 4'h4; #2;
    n_tests++;
    if (a0 !== 64'h30) begin
      n_fail++; $display("FAIL collision_bypass got %h expected %h", a0, 64'h30);
    end
    n_tests++;
    if (a1 !== 64'd10) begin
      n_fail++; $display("FAIL collision_nobypass got %h expected %h", a1, 64'd10);
    end
    @(posedge clk);
    model_edge();
    #1;
    weE = 1'b0; weM = 1'b0;
    dbg_id = 4'h4; #1;
    n_tests++;
    if (d0 !== 64'h30) begin
      n_fail++; $display("FAIL collision_commit got %h expected %h", d0, 64'h30);
    end
    n_tests++;
    if (a1 !== 64'h30) begin
      n_fail++; $display("FAIL collision_after_edge got %h expected %h", a1, 64'h30);
    end
    n_tests++;
    if (e0 !== 1'b0) begin
      n_fail++; $display("FAIL collision_wr_err got %b expected 0", e0);
    end
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    srcB = 4'h7; weE = 1'b1; dstE = 4'h7; valE = 64'h55; weM = 1'b0; #2;
    n_tests++;
    if (b0 !== 64'h55) begin
      n_fail++; $display("FAIL bypass_same_cycle got %h expected %h", b0, 64'h55);
    end
    n_tests++;
    if (b1 !== 64'd7) begin
      n_fail++; $display("FAIL bypass_off_before_edge got %h expected %h", b1, 64'd7);
    end
    @(posedge clk);
    model_edge();
    #1;
    weE = 1'b0; #1;
    n_tests++;
    if (b1 !== 64'h55) begin
      n_fail++; $display("FAIL bypass_off_after_edge got %h expected %h", b1, 64'h55);
    end
  endtask

  task automatic test_invalid();
    @(posedge clk); #1;
    srcA = 4'hF; srcB = 4'hE;
    weE = 1'b1; dstE = 4'hF; valE = 64'h123;
    weM = 1'b1; dstM = 4'hE; valM = 64'h77; #2;
    n_tests++;
    if (a0 !== 64'd0 || a1 !== 64'd0 || a2 !== 32'd0) begin
      n_fail++; $display("FAIL rnone_read got %h/%h/%h expected 0", a0, a1, a2);
    end
    n_tests++;
    if (b0 !== 64'h77 || b1 !== 64'd0) begin
      n_fail++; $display("FAIL id14_read got %h/%h expected %h/0", b0, b1, 64'h77);
    end
    @(posedge clk);
    model_edge();
    #1;
    weE = 1'b0; weM = 1'b0;
    n_tests++;
    if (e0 !== 1'b0 || e1 !== 1'b1 || e2 !== 1'b1) begin
      n_fail++; $display("FAIL wr_err_set got %b%b%b expected 011", e0, e1, e2);
    end
    dbg_id = 4'hE; #1;
    n_tests++;
    if (d0 !== 64'h77 || d1 !== 64'd0) begin
      n_fail++; $display("FAIL invalid_write got %h/%h expected %h/0", d0, d1, 64'h77);
    end
    @(posedge clk); #1;
    n_tests++;
    if (e1 !== 1'b0 || e2 !== 1'b0) begin
      n_fail++; $display("FAIL wr_err_clear got %b%b expected 00", e1, e2);
    end
  endtask

  task automatic test_params();
    @(posedge clk); #1;
    weE = 1'b1; dstE = 4'h7; valE = '1;
    @(posedge clk);
    model_edge();
    #1;
    weE = 1'b0; dbg_id = 4'h7; srcA = 4'h7; #1;
    n_tests++;
    if (d2 !== 32'hFFFF_FFFF || a2 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL param_width got %h/%h expected ffffffff", d2, a2);
    end
  endtask

  task automatic test_random();
    bit do_rst;
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++) begin
      weE    = 1'($urandom_range(0, 1));
      weM    = 1'($urandom_range(0, 1));
      dstE   = 4'($urandom_range(0, 15));
      dstM   = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
      valE   = {$urandom, $urandom};
      valM   = {$urandom, $urandom};
      srcA   = ($urandom_range(0, 2) == 0) ? dstM : 4'($urandom_range(0, 15));
      srcB   = ($urandom_range(0, 2) == 0) ? dstE : 4'($urandom_range(0, 15));
      dbg_id = 4'($urandom_range(0, 15));
      do_rst = ($urandom_range(0, 39) == 0);
      if (do_rst) begin
        rst_n = 1'b0;
        model_reset();
      end
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        n_tests++;
        if (obs_a[k] !== exp_read(k, srcA, 1'b1)) begin
          n_fail++; $display("FAIL rand_valA n=%0d k=%0d got %h expected %h", n, k, obs_a[k], exp_read(k, srcA, 1'b1));
        end
        n_tests++;
        if (obs_b[k] !== exp_read(k, srcB, 1'b1)) begin
          n_fail++; $display("FAIL rand_valB n=%0d k=%0d got %h expected %h", n, k, obs_b[k], exp_read(k, srcB, 1'b1));
        end
        n_tests++;
        if (obs_d[k] !== exp_read(k, dbg_id, 1'b0)) begin
          n_fail++; $display("FAIL rand_dbg n=%0d k=%0d got %h expected %h", n, k, obs_d[k], exp_read(k, dbg_id, 1'b0));
        end
        n_tests++;
        if (obs_e[k] !== exp_err[k]) begin
          n_fail++; $display("FAIL rand_wr_err n=%0d k=%0d got %b expected %b", n, k, obs_e[k], exp_err[k]);
        end
      end
      @(posedge clk);
      if (!do_rst) model_edge();
      #1;
      if (do_rst) rst_n = 1'b1;
    end
    weE = 1'b0; weM = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_collision();
    test_bypass();
    test_invalid();
    test_params();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
